// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round controller.
// Holds the FSM state type, round count and key-schedule constants.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } aes_state_e;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1B;

    // GF(2^8) multiply-by-x, reducing by the AES polynomial on carry-out
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] shifted;
        shifted = {b[6:0], 1'b0};
        xtime   = b[7] ? (shifted ^ RCON_POLY) : shifted;
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Host/datapath-facing signal bundle of the AES round controller.
// master = host/datapath side, slave = controller side.
interface aes_round_ctrl_if;
    import aes_ctrl_pkg::*;

    logic                           start;
    logic                           ack;
    logic                           ld_init;
    logic                           en_round;
    logic                           sel_mix;
    logic [$bits(NUM_ROUNDS)-1:0]   round_num;
    logic [7:0]                     rcon;
    logic                           busy;
    logic                           done;

    modport master (
        output start, ack,
        input  ld_init, en_round, sel_mix, round_num, rcon, busy, done
    );

    modport slave (
        input  start, ack,
        output ld_init, en_round, sel_mix, round_num, rcon, busy, done
    );

endinterface

// File: rtl/aes_rcon_gen.sv
// Sequential AES key-schedule round-constant generator.
// clear wins over load, load wins over advance; otherwise the value holds.
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] rcon
);

    logic [7:0] rcon_r;

    // Round-constant register: reset/clear to zero, load seed, or step by xtime
    always_ff @(posedge clk) begin
        if (reset) begin
            rcon_r <= 8'h00;
        end else if (clear) begin
            rcon_r <= 8'h00;
        end else if (load) begin
            rcon_r <= RCON_INIT;
        end else if (advance) begin
            rcon_r <= xtime(rcon_r);
        end else begin
            rcon_r <= rcon_r;
        end
    end

    assign rcon = rcon_r;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round sequencer: IDLE -> INIT -> ROUND x9 -> FINAL -> DONE.
// All outputs are registered from the next-state decode, so start/ack never reach an output combinationally.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    aes_round_ctrl_if.slave   ctrl
);

    aes_state_e state_r;
    aes_state_e state_nxt_s;
    logic [3:0] round_r;
    logic [3:0] round_nxt_s;
    logic       ld_init_r;
    logic       en_round_r;
    logic       sel_mix_r;
    logic       busy_r;
    logic       done_r;
    logic       rcon_clear_s;
    logic       rcon_load_s;
    logic       rcon_adv_s;
    logic [7:0] rcon_s;

    // Next-state, round counter and round-constant control decode
    always_comb begin
        state_nxt_s  = ST_IDLE;
        round_nxt_s  = 4'd0;
        rcon_clear_s = 1'b0;
        rcon_load_s  = 1'b0;
        rcon_adv_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rcon_clear_s = 1'b1;
                if (ctrl.start) begin
                    state_nxt_s = ST_INIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                state_nxt_s = ST_ROUND;
                round_nxt_s = 4'd1;
                rcon_load_s = 1'b1;
            end
            ST_ROUND: begin
                rcon_adv_s = 1'b1;
                // A corrupted count above 9 also heads for FINAL, so the counter tops out at 10
                if (round_r >= (NUM_ROUNDS - 4'd1)) begin
                    state_nxt_s = ST_FINAL;
                    round_nxt_s = NUM_ROUNDS;
                end else begin
                    state_nxt_s = ST_ROUND;
                    round_nxt_s = round_r + 4'd1;
                end
            end
            ST_FINAL: begin
                state_nxt_s = ST_DONE;
                round_nxt_s = NUM_ROUNDS;
            end
            ST_DONE: begin
                if (ctrl.ack) begin
                    state_nxt_s  = ST_IDLE;
                    rcon_clear_s = 1'b1;
                end else if (ctrl.start) begin
                    state_nxt_s  = ST_INIT;
                    rcon_clear_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DONE;
                    round_nxt_s = NUM_ROUNDS;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                rcon_clear_s = 1'b1;
            end
        endcase
    end

    // State, round counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            round_r    <= 4'd0;
            ld_init_r  <= 1'b0;
            en_round_r <= 1'b0;
            sel_mix_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            round_r    <= round_nxt_s;
            ld_init_r  <= (state_nxt_s == ST_INIT);
            en_round_r <= (state_nxt_s == ST_ROUND) || (state_nxt_s == ST_FINAL);
            sel_mix_r  <= (state_nxt_s == ST_ROUND);
            busy_r     <= (state_nxt_s == ST_INIT) || (state_nxt_s == ST_ROUND) ||
                          (state_nxt_s == ST_FINAL);
            done_r     <= (state_nxt_s == ST_DONE);
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (rcon_clear_s),
        .load    (rcon_load_s),
        .advance (rcon_adv_s),
        .rcon    (rcon_s)
    );

    assign ctrl.ld_init   = ld_init_r;
    assign ctrl.en_round  = en_round_r;
    assign ctrl.sel_mix   = sel_mix_r;
    assign ctrl.round_num = round_r;
    assign ctrl.rcon      = rcon_s;
    assign ctrl.busy      = busy_r;
    assign ctrl.done      = done_r;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL expose ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL expose: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL expose: start  in  1  request one AES-128 encryption; sampled only in IDLE.
REQ-004 SHALL expose: ack  in  1  host has read the result; releases DONE.
REQ-005 SHALL expose: ld_init  out  1  load message/key shift-register contents into the datapath and apply the round-0 AddRoundKey.
REQ-006 SHALL expose: en_round  out  1  datapath executes one round this cycle.
REQ-007 SHALL expose: sel_mix  out  1  1 = include MixColumns; 0 = final round (bypass).
REQ-008 SHALL expose: round_num  out  4  current round index, 0..10.
REQ-009 SHALL expose: rcon  out  8  key-schedule round constant for round_num.
REQ-010 SHALL expose: busy  out  1  encryption in progress.
REQ-011 SHALL expose: done  out  1  result valid in datapath output register.

Function
REQ-012 SHALL implement FSM states IDLE, INIT, ROUND, FINAL, DONE.
REQ-013 IDLE: start=1 -> INIT; else stay. All outputs 0.
REQ-014 INIT (1 cycle): ld_init=1, round_num=0, busy=1, rcon=00 -> ROUND.
REQ-015 ROUND: en_round=1, sel_mix=1, busy=1; round_num counts 1..9, one cycle each; after round 9 -> FINAL.
REQ-016 FINAL (1 cycle): en_round=1, sel_mix=0, busy=1, round_num=10 -> DONE.
REQ-017 DONE: done=1, busy=0, round_num holds 10; ack=1 -> IDLE; start=1 with ack=0 -> INIT (restart; start has priority only when ack=0).
REQ-018 SHALL assert done exactly 12 cycles after the rising edge that samples start in IDLE (INIT 1 + ROUND 9 + FINAL 1 + 1).
REQ-019 rcon SHALL be 01,02,04,08,10,20,40,80,1B,36 for round_num 1..10 and 00 for round_num 0 or in IDLE.
REQ-020 rcon SHALL be generated sequentially: 01 on entry to round 1, then xtime (shift left, XOR 1B on carry-out) each round.
REQ-021 start asserted in INIT, ROUND or FINAL SHALL be ignored (no queuing).
REQ-022 ack outside DONE SHALL be ignored.
REQ-023 start and ack both 1 in DONE -> IDLE (ack wins); a new start is accepted on a later cycle.
REQ-024 round counter SHALL never exceed 10; any illegal state encoding -> IDLE next cycle.
REQ-025 All outputs SHALL be registered or decoded purely from registered state; no combinational path from start/ack to outputs.

Reset
REQ-026 reset=1 on a rising edge SHALL force IDLE, round_num=0, rcon=00, and ld_init, en_round, sel_mix, busy, done = 0, from any state including mid-encryption.
REQ-027 Inputs SHALL be ignored in the cycle reset is high; start held high through reset release is accepted on the first post-reset edge.

Structure
REQ-028 A shared package aes_ctrl_pkg SHALL hold the state enum type, NUM_ROUNDS=10, RCON_INIT=8'h01 and RCON_POLY=8'h1B.
REQ-029 The rcon xtime step SHALL be a sub-module aes_rcon_gen (load, advance, clear; 8-bit out).
REQ-030 Counter and FSM SHALL live in aes_round_ctrl; no datapath logic in this block.

Verification
REQ-031 reset, start pulse at cycle 0 -> ld_init at cycle 1, en_round cycles 2..11, sel_mix=0 only at cycle 11, done=1 at cycle 12.
REQ-032 Full run -> rcon trace 01,02,04,08,10,20,40,80,1B,36 aligned with round_num 1..10.
REQ-033 start re-pulsed at round 5 -> ignored; done still at cycle 12, no second INIT.
REQ-034 reset asserted at round 7 -> next cycle IDLE, all outputs 0; subsequent start completes normally in 12 cycles.
REQ-035 In DONE: ack=1 -> IDLE next cycle; start=1, ack=0 -> INIT next cycle; start=ack=1 -> IDLE.
REQ-036 Hold done 20 cycles without ack -> done stays 1, round_num stays 10, busy 0.
